// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants and types for fetch, decode and Imm_Gen
package riscv_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    RUN      = 2'd1,
    FLUSH    = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order {pc, instr} queue with flush, push, pop and occupancy count
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [2*XLEN-1:0] wdata,
  input  logic              pop,
  output logic [2*XLEN-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;

  // Callers never push when full nor pop when empty, so no guards here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I fetch stage: PC, imem requests, prefetch queue, redirects
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        protocol_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state, state_d;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding, outstanding_d;
  logic [CW-1:0] drop_cnt, drop_cnt_d;
  logic [CW-1:0] occ, tag_count;
  logic [CW:0]   inflight;
  logic          req_hs, rsp_acc, rsp_keep, pop;
  logic [63:0]   tag_rdata, q_rdata;
  logic          q_empty, tag_empty;
  logic [31:0]   last_pc, last_instr;
  logic          tag_unused;

  // Dropped-but-in-flight requests still count, so the queue can never overflow.
  assign inflight       = {1'b0, outstanding} + {1'b0, occ};
  assign imem_req_valid = (state != RST_WAIT) && (inflight < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_hs        = imem_req_valid && imem_req_ready;
  assign rsp_acc       = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep      = rsp_acc && (drop_cnt == '0) && !redirect_valid;
  assign pop           = if_valid && if_ready && !redirect_valid;
  assign outstanding_d = outstanding + CW'(req_hs) - CW'(rsp_acc);

  always_comb begin
    drop_cnt_d = drop_cnt;
    state_d    = state;
    if (redirect_valid)
      drop_cnt_d = outstanding_d;
    else if (rsp_acc && (drop_cnt != '0))
      drop_cnt_d = drop_cnt - 1'b1;
    case (state)
      RST_WAIT:  state_d = RUN;
      RUN, FLUSH: state_d = (drop_cnt_d != '0) ? FLUSH : RUN;
      default:   state_d = RST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RST_WAIT;
      fetch_pc     <= RESET_PC;
      outstanding  <= '0;
      drop_cnt     <= '0;
      protocol_err <= 1'b0;
      last_pc      <= '0;
      last_instr   <= NOP_INSTR;
    end else begin
      state       <= state_d;
      outstanding <= outstanding_d;
      drop_cnt    <= drop_cnt_d;
      if (redirect_valid)
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (req_hs)
        fetch_pc <= fetch_pc + 32'd4;
      if (imem_rsp_valid && (outstanding == '0))
        protocol_err <= 1'b1;
      if (pop) begin
        last_pc    <= q_rdata[63:32];
        last_instr <= q_rdata[31:0];
      end
    end
  end

  // Tag queue: PCs of live requests, popped as their responses are kept.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (req_hs && !redirect_valid),
    .wdata ({fetch_pc, NOP_INSTR}),
    .pop   (rsp_keep),
    .rdata (tag_rdata),
    .count (tag_count),
    .empty (tag_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_data_q (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (rsp_keep),
    .wdata ({tag_rdata[63:32], imem_rsp_data}),
    .pop   (pop),
    .rdata (q_rdata),
    .count (occ),
    .empty (q_empty)
  );

  assign tag_unused = ^{tag_count, tag_empty, tag_rdata[31:0]};

  assign if_valid = !q_empty;
  assign if_pc    = q_empty ? last_pc    : q_rdata[63:32];
  assign if_instr = q_empty ? last_instr : q_rdata[31:0];
endmodule
